// File: rtl/fd_delay_line_pkg.sv
// Shared constants, FSM state type and small helpers for the fine-delay line loader.
// Channel count and tap-bus width match the MC100EP195 layout on the Fine Delay FMC.
package fd_delay_line_pkg;

    localparam int c_fd_num_channels    = 4;
    localparam int c_fd_delay_val_width = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD
    } t_fd_dly_load_state;

    // Used at elaboration to size the phase counter for the longest phase.
    function automatic int fd_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/fd_rr_arbiter.sv
// Generic N-requester round-robin arbiter: one-hot grant, scanning from last_grant+1.
// The priority pointer only moves when the owner strobes grant_en on a valid grant.
module fd_rr_arbiter #(
    parameter int g_num_req   = 4,
    parameter int g_idx_width = 2
) (
    input  logic                   sclk,
    input  logic                   reset,
    input  logic [g_num_req-1:0]   req,
    input  logic                   grant_en,
    output logic [g_num_req-1:0]   grant,
    output logic [g_idx_width-1:0] grant_idx,
    output logic                   grant_valid
);

    logic [g_idx_width-1:0] last_grant;
    logic [g_idx_width-1:0] scan;

    // First requester after the previous winner wins; the previous winner comes last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        scan        = '0;
        for (int k = 1; k <= g_num_req; k++) begin
            scan = g_idx_width'((int'(last_grant) + k) % g_num_req);
            if (!grant_valid && req[scan]) begin
                grant_valid = 1'b1;
                grant_idx   = scan;
                grant[scan] = 1'b1;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            last_grant <= g_idx_width'(g_num_req - 1);
        end else if (grant_en && grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/fd_delay_line_loader.sv
// Sequences setup / latch-open / hold programming of the four MC100EP195 fine-delay lines
// over the shared delay_val bus, serving per-channel load requests round-robin.
module fd_delay_line_loader
    import fd_delay_line_pkg::*;
#(
    parameter int g_setup_cycles = 2,
    parameter int g_open_cycles  = 2,
    parameter int g_hold_cycles  = 1
) (
    input  logic                                                clk_ref_i,
    input  logic                                                rst_i,
    input  logic [c_fd_num_channels-1:0]                        req_valid_i,
    input  logic [c_fd_num_channels*c_fd_delay_val_width-1:0]   req_value_i,
    input  logic [c_fd_num_channels-1:0]                        chan_busy_i,
    output logic [c_fd_num_channels-1:0]                        req_ack_o,
    output logic [c_fd_num_channels-1:0]                        load_done_o,
    output logic [c_fd_delay_val_width-1:0]                     delay_val_o,
    output logic [c_fd_num_channels-1:0]                        delay_len_o,
    output logic                                                busy_o
);

    localparam int c_chan_w    = $clog2(c_fd_num_channels);
    localparam int c_phase_max = fd_max3(g_setup_cycles, g_open_cycles, g_hold_cycles);
    localparam int c_phase_w   = $clog2(c_phase_max + 1);

    // Phases count down to zero, so each is loaded with its length minus one.
    localparam logic [c_phase_w-1:0] c_setup_load = c_phase_w'(g_setup_cycles - 1);
    localparam logic [c_phase_w-1:0] c_open_load  = c_phase_w'(g_open_cycles - 1);
    localparam logic [c_phase_w-1:0] c_hold_load  = c_phase_w'(g_hold_cycles - 1);
    localparam logic [c_phase_w-1:0] c_phase_one  = c_phase_w'(1);

    t_fd_dly_load_state               state, state_nxt;
    logic [c_phase_w-1:0]             phase, phase_nxt;
    logic [c_chan_w-1:0]              chan, chan_nxt;
    logic [c_fd_delay_val_width-1:0]  val_nxt;
    logic [c_fd_num_channels-1:0]     len_nxt;
    logic [c_fd_num_channels-1:0]     ack_nxt;
    logic [c_fd_num_channels-1:0]     done_nxt;
    logic                             busy_nxt;

    logic [c_fd_num_channels-1:0]     eligible;
    logic [c_fd_num_channels-1:0]     grant;
    logic [c_chan_w-1:0]              grant_idx;
    logic                             grant_valid;
    logic                             grant_en;

    logic [c_fd_delay_val_width-1:0]  req_value [c_fd_num_channels];

    for (genvar n = 0; n < c_fd_num_channels; n++) begin : g_unpack
        assign req_value[n] = req_value_i[n*c_fd_delay_val_width +: c_fd_delay_val_width];
    end

    // Busy channels are masked out; the mask only matters while the FSM sits in IDLE.
    assign eligible = req_valid_i & ~chan_busy_i;

    fd_rr_arbiter #(
        .g_num_req   (c_fd_num_channels),
        .g_idx_width (c_chan_w)
    ) u_arbiter (
        .sclk        (clk_ref_i),
        .reset       (rst_i),
        .req         (eligible),
        .grant_en    (grant_en),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Next-state and next-output logic; every output is the registered copy of a *_nxt value.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        chan_nxt  = chan;
        val_nxt   = delay_val_o;
        ack_nxt   = '0;
        done_nxt  = '0;
        grant_en  = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant_en  = 1'b1;
                    state_nxt = SETUP;
                    phase_nxt = c_setup_load;
                    chan_nxt  = grant_idx;
                    val_nxt   = req_value[grant_idx];
                    ack_nxt   = grant;
                end
            end
            SETUP: begin
                if (phase == '0) begin
                    state_nxt = OPEN;
                    phase_nxt = c_open_load;
                end else begin
                    phase_nxt = phase - c_phase_one;
                end
            end
            OPEN: begin
                if (phase == '0) begin
                    state_nxt = HOLD;
                    phase_nxt = c_hold_load;
                end else begin
                    phase_nxt = phase - c_phase_one;
                end
            end
            HOLD: begin
                if (phase == '0) begin
                    state_nxt      = IDLE;
                    phase_nxt      = '0;
                    done_nxt[chan] = 1'b1;
                end else begin
                    phase_nxt = phase - c_phase_one;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase

        // Only the granted chip's latch goes transparent, and only during OPEN.
        len_nxt = '1;
        if (state_nxt == OPEN) begin
            len_nxt[chan_nxt] = 1'b0;
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            state       <= IDLE;
            phase       <= '0;
            chan        <= '0;
            delay_val_o <= '0;
            delay_len_o <= '1;
            req_ack_o   <= '0;
            load_done_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            chan        <= chan_nxt;
            delay_val_o <= val_nxt;
            delay_len_o <= len_nxt;
            req_ack_o   <= ack_nxt;
            load_done_o <= done_nxt;
            busy_o      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_fd_delay_line_loader.sv
// Bench for fd_delay_line_loader: two instances (default and S=1/O=4/H=3 timing),
// a cycle-offset reference model checked every cycle, plus directed literal checks.
module tb_fd_delay_line_loader;

    localparam int SA = 2, OA = 2, HA = 1;
    localparam int SB = 1, OB = 4, HB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rv_a, cb_a, rv_b, cb_b;
    logic [39:0] vals_a, vals_b;
    logic [3:0]  ack_a, done_a, len_a, ack_b, done_b, len_b;
    logic [9:0]  val_a, val_b;
    logic        busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit model_on = 1'b0;

    bit         m_active [2];
    int         m_t0     [2];
    int         m_chan   [2];
    logic [9:0] m_val    [2];
    int         m_last   [2];

    always #5 clk = ~clk;

    fd_delay_line_loader #(
        .g_setup_cycles (SA), .g_open_cycles (OA), .g_hold_cycles (HA)
    ) dut_a (
        .clk_ref_i   (clk),
        .rst_i       (rst),
        .req_valid_i (rv_a),
        .req_value_i (vals_a),
        .chan_busy_i (cb_a),
        .req_ack_o   (ack_a),
        .load_done_o (done_a),
        .delay_val_o (val_a),
        .delay_len_o (len_a),
        .busy_o      (busy_a)
    );

    fd_delay_line_loader #(
        .g_setup_cycles (SB), .g_open_cycles (OB), .g_hold_cycles (HB)
    ) dut_b (
        .clk_ref_i   (clk),
        .rst_i       (rst),
        .req_valid_i (rv_b),
        .req_value_i (vals_b),
        .chan_busy_i (cb_b),
        .req_ack_o   (ack_b),
        .load_done_o (done_b),
        .delay_val_o (val_b),
        .delay_len_o (len_b),
        .busy_o      (busy_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic [3:0] valid,
                                 input logic [39:0] values, input logic [3:0] busy);
        if (inst == 0) begin
            rv_a = valid; vals_a = values; cb_a = busy;
        end else begin
            rv_b = valid; vals_b = values; cb_b = busy;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int oneIdx(input logic [3:0] x);
        for (int i = 0; i < 4; i++) if (x[i]) return i;
        return -1;
    endfunction

    // Expected outputs follow from how many cycles have passed since the grant cycle.
    task automatic modelCompare(input int i, input int s, input int o, input int h,
                                input logic [3:0] ack, input logic [3:0] done,
                                input logic [3:0] len, input logic [9:0] val, input logic busy);
        logic [3:0] e_ack, e_done, e_len;
        logic       e_busy;
        int         d;
        e_ack = '0; e_done = '0; e_len = 4'hF; e_busy = 1'b0;
        if (m_active[i]) begin
            d = cyc - m_t0[i];
            if (d == 1) e_ack[m_chan[i]] = 1'b1;
            if (d >= s + 1 && d <= s + o) e_len[m_chan[i]] = 1'b0;
            e_busy = (d >= 1 && d <= s + o + h);
            if (d == s + o + h + 1) e_done[m_chan[i]] = 1'b1;
        end
        checkOutput(i == 0 ? "A.ack"  : "B.ack",  32'(ack),  32'(e_ack));
        checkOutput(i == 0 ? "A.done" : "B.done", 32'(done), 32'(e_done));
        checkOutput(i == 0 ? "A.len"  : "B.len",  32'(len),  32'(e_len));
        checkOutput(i == 0 ? "A.val"  : "B.val",  32'(val),  32'(m_val[i]));
        checkOutput(i == 0 ? "A.busy" : "B.busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic modelAdvance(input int i, input int s, input int o, input int h,
                                input logic r, input logic [3:0] v,
                                input logic [39:0] vals, input logic [3:0] b);
        logic [3:0] elig;
        int c;
        if (r) begin
            m_active[i] = 1'b0;
            m_val[i]    = '0;
            m_last[i]   = 3;
            return;
        end
        if (m_active[i] && (cyc - m_t0[i]) > s + o + h) m_active[i] = 1'b0;
        if (!m_active[i]) begin
            elig = v & ~b;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last[i] + k) % 4;
                if (elig[c]) begin
                    m_active[i] = 1'b1;
                    m_t0[i]     = cyc;
                    m_chan[i]   = c;
                    m_last[i]   = c;
                    m_val[i]    = vals[c*10 +: 10];
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (model_on) begin
            modelCompare(0, SA, OA, HA, ack_a, done_a, len_a, val_a, busy_a);
            modelCompare(1, SB, OB, HB, ack_b, done_b, len_b, val_b, busy_b);
        end
        modelAdvance(0, SA, OA, HA, rst, rv_a, vals_a, cb_a);
        modelAdvance(1, SB, OB, HB, rst, rv_b, vals_b, cb_b);
    end

    initial begin
        logic [3:0]  v;
        logic [39:0] vals;
        int          ack_at [4];
        int          order [$];
        int          n_ack;
        int          idx;

        rst = 1'b1;
        applyStimulus(0, '0, '0, '0);
        applyStimulus(1, '0, '0, '0);
        step();
        step();
        model_on = 1'b1;
        step();

        checkOutput("reset len",  32'(len_a),  'hF);
        checkOutput("reset val",  32'(val_a),  0);
        checkOutput("reset busy", 32'(busy_a), 0);
        checkOutput("reset ack",  32'(ack_a),  0);
        checkOutput("reset done", 32'(done_a), 0);
        checkOutput("reset lenB", 32'(len_b),  'hF);
        rst = 1'b0;
        step();

        // Single load on channel 2
        vals = {10'h000, 10'h2A5, 10'h000, 10'h000};
        applyStimulus(0, 4'b0100, vals, '0);
        for (int k = 1; k <= 6; k++) begin
            step();
            checkOutput("single ack",  32'(ack_a),  (k == 1) ? 'h4 : 0);
            checkOutput("single val",  32'(val_a),  'h2A5);
            checkOutput("single len",  32'(len_a),  (k == 3 || k == 4) ? 'hB : 'hF);
            checkOutput("single done", 32'(done_a), (k == 6) ? 'h4 : 0);
            checkOutput("single busy", 32'(busy_a), (k <= 5) ? 1 : 0);
            if (k == 1) applyStimulus(0, '0, vals, '0);
        end

        // Contention: all four pending at reset release
        rst  = 1'b1;
        v    = 4'hF;
        vals = {10'h008, 10'h004, 10'h002, 10'h001};
        applyStimulus(0, v, vals, '0);
        step();
        step();
        rst   = 1'b0;
        n_ack = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (ack_a != 0) begin
                idx = oneIdx(ack_a);
                checkOutput("rr ack chan",  idx, n_ack);
                checkOutput("rr ack cycle", k, 1 + 6 * n_ack);
                n_ack++;
                if (idx >= 0) v[idx] = 1'b0;
                applyStimulus(0, v, vals, '0);
            end
            if (len_a != 4'hF) begin
                idx = oneIdx(~len_a);
                checkOutput("rr len value", 32'(val_a), 1 << idx);
            end
        end
        checkOutput("rr ack count", n_ack, 4);

        // Busy masking: ch1 blocked by busy, ch3 free
        v    = 4'b1010;
        vals = {10'h3C3, 10'h000, 10'h155, 10'h000};
        for (int i = 0; i < 4; i++) ack_at[i] = -1;
        applyStimulus(0, v, vals, 4'b0010);
        for (int k = 1; k <= 18; k++) begin
            step();
            idx = oneIdx(ack_a);
            if (idx >= 0) begin
                if (ack_at[idx] < 0) ack_at[idx] = k;
                v[idx] = 1'b0;
            end
            if (k == 10) checkOutput("mask idle before release", 32'(busy_a), 0);
            applyStimulus(0, v, vals, (k >= 10) ? 4'b0000 : 4'b0010);
        end
        checkOutput("mask ch3 ack", ack_at[3], 1);
        checkOutput("mask ch1 ack", ack_at[1], 11);

        // Fairness: ch0 and ch1 both re-request after every ack
        v    = 4'b0011;
        vals = {10'h000, 10'h000, 10'h10F, 10'h0F0};
        applyStimulus(0, v, vals, '0);
        order.delete();
        for (int k = 1; k <= 26; k++) begin
            step();
            idx = oneIdx(ack_a);
            if (idx >= 0) begin
                order.push_back(idx);
                vals[idx*10 +: 10] = vals[idx*10 +: 10] + 10'd1;
                if (order.size() >= 4) v = '0;
                applyStimulus(0, v, vals, '0);
            end
        end
        for (int n = 0; n < 4; n++)
            checkOutput("fair order", (order.size() > n) ? order[n] : -1, n % 2);

        // Reset during the first OPEN cycle of ch0
        vals = {10'h000, 10'h000, 10'h000, 10'h1AB};
        applyStimulus(0, 4'b0001, vals, '0);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) checkOutput("rstopen first ack", 32'(ack_a), 1);
            if (k == 3) begin
                checkOutput("rstopen len open", 32'(len_a), 'hE);
                rst = 1'b1;
            end
            if (k == 4) begin
                checkOutput("rstopen len", 32'(len_a), 'hF);
                checkOutput("rstopen busy", 32'(busy_a), 0);
                checkOutput("rstopen val", 32'(val_a), 0);
                rst = 1'b0;
            end
            if (k >= 4 && k <= 9) checkOutput("rstopen no done", 32'(done_a), 0);
            if (k == 5) begin
                checkOutput("rstopen reack", 32'(ack_a), 1);
                applyStimulus(0, '0, vals, '0);
            end
            if (k == 10) checkOutput("rstopen done", 32'(done_a), 1);
        end

        // Alternate timing instance: S=1, O=4, H=3 on channel 1
        vals = {10'h000, 10'h000, 10'h333, 10'h000};
        applyStimulus(1, 4'b0010, vals, '0);
        for (int k = 1; k <= 10; k++) begin
            step();
            checkOutput("param ack",  32'(ack_b),  (k == 1) ? 'h2 : 0);
            checkOutput("param val",  32'(val_b),  'h333);
            checkOutput("param len",  32'(len_b),  (k >= 2 && k <= 5) ? 'hD : 'hF);
            checkOutput("param done", 32'(done_b), (k == 9) ? 'h2 : 0);
            checkOutput("param busy", 32'(busy_b), (k <= 8) ? 1 : 0);
            if (k == 1) applyStimulus(1, '0, vals, '0);
        end

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
